// File: rtl/rename_map_stage.sv
// Rename stage: speculative RAT, physical-register ready vector and a single
// output register toward dispatch. One instruction renamed per cycle.
module rename_map_stage #(
  parameter int unsigned NUM_REGS = 64,
  localparam int unsigned PW = $clog2(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [31:0][PW-1:0]  rrf_arch_to_physical_i,
  // Decode side
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [4:0]           dec_rs1_i,
  input  logic [4:0]           dec_rs2_i,
  input  logic [4:0]           dec_rd_i,
  input  logic                 dec_rd_we_i,
  // Free list
  output logic                 need_free_reg_o,
  output logic [4:0]           arch_rd_o,
  input  logic [PW-1:0]        free_reg_i,
  input  logic                 reg_available_i,
  // Writeback broadcast
  input  logic                 cdb_valid_i,
  input  logic [PW-1:0]        cdb_pd_i,
  // Dispatch side
  output logic                 ren_valid_o,
  input  logic                 ren_ready_i,
  output logic [PW-1:0]        ren_ps1_o,
  output logic [PW-1:0]        ren_ps2_o,
  output logic [PW-1:0]        ren_pd_o,
  output logic [PW-1:0]        ren_old_pd_o,
  output logic                 ren_ps1_rdy_o,
  output logic                 ren_ps2_rdy_o,
  output logic [NUM_REGS-1:0]  phys_ready_o
);

  // Speculative map and ready vector
  logic [PW-1:0]       map_q [32];
  logic [PW-1:0]       map_d [32];
  logic [NUM_REGS-1:0] phys_ready_q, phys_ready_d;

  // Output register
  logic          ren_valid_q, ren_valid_d;
  logic [PW-1:0] ren_ps1_q, ren_ps1_d;
  logic [PW-1:0] ren_ps2_q, ren_ps2_d;
  logic [PW-1:0] ren_pd_q, ren_pd_d;
  logic [PW-1:0] ren_old_pd_q, ren_old_pd_d;
  logic          ren_ps1_rdy_q, ren_ps1_rdy_d;
  logic          ren_ps2_rdy_q, ren_ps2_rdy_d;

  logic          alloc, fire;
  logic [PW-1:0] ps1, ps2, old_pd;
  logic          ps1_rdy, ps2_rdy;

  // The committed map of x0 is never consumed; x0 is pinned to tag 0.
  logic unused_rrf0;
  assign unused_rrf0 = ^rrf_arch_to_physical_i[0];

  assign alloc           = dec_rd_we_i && (dec_rd_i != 5'd0);
  assign dec_ready_o     = !flush_i && (!ren_valid_q || ren_ready_i) &&
                           (!alloc || reg_available_i);
  assign fire            = dec_valid_i && dec_ready_o;
  assign need_free_reg_o = fire && alloc;
  assign arch_rd_o       = dec_rd_i;

  // Lookups read the pre-update map, so rs==rd sees the previous tag.
  assign ps1    = map_q[dec_rs1_i];
  assign ps2    = map_q[dec_rs2_i];
  assign old_pd = map_q[dec_rd_i];

  // Source is ready if already written back or being broadcast right now.
  assign ps1_rdy = (ps1 == '0) || phys_ready_q[ps1] || (cdb_valid_i && (cdb_pd_i == ps1));
  assign ps2_rdy = (ps2 == '0) || phys_ready_q[ps2] || (cdb_valid_i && (cdb_pd_i == ps2));

  // Next map: flush restores the committed map, otherwise allocate on fire.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      map_d[i] = map_q[i];
    end
    if (flush_i) begin
      for (int i = 1; i < 32; i++) begin
        map_d[i] = rrf_arch_to_physical_i[i];
      end
      map_d[0] = '0;
    end else if (fire && alloc) begin
      map_d[dec_rd_i] = free_reg_i;
    end
  end

  // Next ready vector: CDB sets, allocation clears (clear wins), tag 0 pinned.
  always_comb begin
    phys_ready_d = phys_ready_q;
    if (flush_i) begin
      phys_ready_d = '1;
    end else begin
      if (cdb_valid_i && (cdb_pd_i != '0)) begin
        phys_ready_d[cdb_pd_i] = 1'b1;
      end
      if (fire && alloc && (free_reg_i != '0)) begin
        phys_ready_d[free_reg_i] = 1'b0;
      end
    end
    phys_ready_d[0] = 1'b1;
  end

  // Next output register: load on fire, drain on accept, snoop CDB while held.
  always_comb begin
    ren_valid_d   = ren_valid_q;
    ren_ps1_d     = ren_ps1_q;
    ren_ps2_d     = ren_ps2_q;
    ren_pd_d      = ren_pd_q;
    ren_old_pd_d  = ren_old_pd_q;
    ren_ps1_rdy_d = ren_ps1_rdy_q;
    ren_ps2_rdy_d = ren_ps2_rdy_q;
    if (flush_i) begin
      ren_valid_d = 1'b0;
    end else if (fire) begin
      ren_valid_d   = 1'b1;
      ren_ps1_d     = ps1;
      ren_ps2_d     = ps2;
      ren_pd_d      = alloc ? free_reg_i : '0;
      ren_old_pd_d  = old_pd;
      ren_ps1_rdy_d = ps1_rdy;
      ren_ps2_rdy_d = ps2_rdy;
    end else if (ren_valid_q && ren_ready_i) begin
      ren_valid_d = 1'b0;
    end else if (ren_valid_q) begin
      if (cdb_valid_i && (cdb_pd_i == ren_ps1_q)) begin
        ren_ps1_rdy_d = 1'b1;
      end
      if (cdb_valid_i && (cdb_pd_i == ren_ps2_q)) begin
        ren_ps2_rdy_d = 1'b1;
      end
    end
  end

  // Map state with identity reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        map_q[i] <= PW'(i);
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        map_q[i] <= map_d[i];
      end
    end
  end

  // Ready vector state; every register starts ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phys_ready_q <= '1;
    end else begin
      phys_ready_q <= phys_ready_d;
    end
  end

  // Output register state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ren_valid_q   <= 1'b0;
      ren_ps1_q     <= '0;
      ren_ps2_q     <= '0;
      ren_pd_q      <= '0;
      ren_old_pd_q  <= '0;
      ren_ps1_rdy_q <= 1'b0;
      ren_ps2_rdy_q <= 1'b0;
    end else begin
      ren_valid_q   <= ren_valid_d;
      ren_ps1_q     <= ren_ps1_d;
      ren_ps2_q     <= ren_ps2_d;
      ren_pd_q      <= ren_pd_d;
      ren_old_pd_q  <= ren_old_pd_d;
      ren_ps1_rdy_q <= ren_ps1_rdy_d;
      ren_ps2_rdy_q <= ren_ps2_rdy_d;
    end
  end

  assign ren_valid_o   = ren_valid_q;
  assign ren_ps1_o     = ren_ps1_q;
  assign ren_ps2_o     = ren_ps2_q;
  assign ren_pd_o      = ren_pd_q;
  assign ren_old_pd_o  = ren_old_pd_q;
  assign ren_ps1_rdy_o = ren_ps1_rdy_q;
  assign ren_ps2_rdy_o = ren_ps2_rdy_q;
  assign phys_ready_o  = phys_ready_q;

endmodule

// File: tb/tb_rename_map_stage.sv
// Bench for rename_map_stage: architectural model plus directed scenarios.
module tb_rename_map_stage;
  localparam int NR = 64;
  localparam int PW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, flush;
  logic [31:0][PW-1:0] rrf;
  logic                dec_valid, dec_ready, dec_rd_we;
  logic [4:0]          dec_rs1, dec_rs2, dec_rd, arch_rd;
  logic                need_free_reg, reg_available;
  logic [PW-1:0]       free_reg;
  logic                cdb_valid;
  logic [PW-1:0]       cdb_pd;
  logic                ren_valid, ren_ready;
  logic [PW-1:0]       ren_ps1, ren_ps2, ren_pd, ren_old_pd;
  logic                ren_ps1_rdy, ren_ps2_rdy;
  logic [NR-1:0]       phys_ready;

  rename_map_stage #(.NUM_REGS(NR)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rrf_arch_to_physical_i(rrf),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_rs1_i(dec_rs1),
    .dec_rs2_i(dec_rs2), .dec_rd_i(dec_rd), .dec_rd_we_i(dec_rd_we),
    .need_free_reg_o(need_free_reg), .arch_rd_o(arch_rd), .free_reg_i(free_reg),
    .reg_available_i(reg_available), .cdb_valid_i(cdb_valid), .cdb_pd_i(cdb_pd),
    .ren_valid_o(ren_valid), .ren_ready_i(ren_ready), .ren_ps1_o(ren_ps1),
    .ren_ps2_o(ren_ps2), .ren_pd_o(ren_pd), .ren_old_pd_o(ren_old_pd),
    .ren_ps1_rdy_o(ren_ps1_rdy), .ren_ps2_rdy_o(ren_ps2_rdy), .phys_ready_o(phys_ready)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: map as an array, readiness as a bit per tag.
  logic [PW-1:0] m_map [32];
  logic [NR-1:0] m_rdy;
  logic          m_valid, m_r1, m_r2;
  logic [PW-1:0] m_ps1, m_ps2, m_pd, m_old;

  function automatic logic m_alloc();
    return dec_rd_we && (dec_rd != 5'd0);
  endfunction

  function automatic logic m_dready();
    return !flush && (!m_valid || ren_ready) && (!m_alloc() || reg_available);
  endfunction

  function automatic logic m_src_rdy(input logic [PW-1:0] p);
    return (p == 0) || m_rdy[p] || (cdb_valid && cdb_pd == p);
  endfunction

  always @(posedge clk) begin : model
    logic [PW-1:0] a, b, o;
    logic fire, al;
    al   = m_alloc();
    fire = dec_valid && m_dready();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_map[i] = PW'(i);
      m_rdy = '1; m_valid = 0;
      m_ps1 = 0; m_ps2 = 0; m_pd = 0; m_old = 0; m_r1 = 0; m_r2 = 0;
    end else if (flush) begin
      for (int i = 1; i < 32; i++) m_map[i] = rrf[i];
      m_map[0] = 0;
      m_rdy = '1; m_valid = 0;
    end else begin
      a = m_map[dec_rs1]; b = m_map[dec_rs2]; o = m_map[dec_rd];
      if (fire) begin
        m_valid = 1; m_ps1 = a; m_ps2 = b; m_old = o;
        m_pd = al ? free_reg : '0;
        m_r1 = m_src_rdy(a); m_r2 = m_src_rdy(b);
      end else if (m_valid && !ren_ready) begin
        if (cdb_valid && cdb_pd == m_ps1) m_r1 = 1;
        if (cdb_valid && cdb_pd == m_ps2) m_r2 = 1;
      end else begin
        m_valid = 0;
      end
      if (cdb_valid && cdb_pd != 0) m_rdy[cdb_pd] = 1;
      if (fire && al && free_reg != 0) m_rdy[free_reg] = 0;
      if (fire && al) m_map[dec_rd] = free_reg;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ren_valid", ren_valid, m_valid);
      if (m_valid) begin
        chk("m_ps1", ren_ps1, m_ps1);
        chk("m_ps2", ren_ps2, m_ps2);
        chk("m_pd", ren_pd, m_pd);
        chk("m_old_pd", ren_old_pd, m_old);
        chk("m_ps1_rdy", ren_ps1_rdy, m_r1);
        chk("m_ps2_rdy", ren_ps2_rdy, m_r2);
      end
      chk("m_phys_ready", phys_ready, m_rdy);
      chk("m_dec_ready", dec_ready, m_dready());
      chk("m_need_free", need_free_reg, dec_valid && m_dready() && m_alloc());
      chk("m_arch_rd", arch_rd, dec_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic we, input logic [PW-1:0] fr);
    dec_valid = v; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd; dec_rd_we = we; free_reg = fr;
  endtask

  initial begin
    rst = 1; flush = 0; ren_ready = 1; reg_available = 1;
    cdb_valid = 0; cdb_pd = 0;
    for (int i = 0; i < 32; i++) rrf[i] = PW'(i);
    dec(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 0; chk_en = 1;
    chk("rst_valid", ren_valid, 0);
    chk("rst_phys_ready", phys_ready, {64{1'b1}});
    chk("rst_pd", ren_pd, 0);

    // add x5,x1,x2
    dec(1, 1, 2, 5, 1, 32);
    #1 chk("t1_need_free", need_free_reg, 1);
    tick();
    chk("t1_valid", ren_valid, 1);
    chk("t1_ps1", ren_ps1, 1);
    chk("t1_ps2", ren_ps2, 2);
    chk("t1_pd", ren_pd, 32);
    chk("t1_old", ren_old_pd, 5);
    chk("t1_rdy1", ren_ps1_rdy, 1);
    chk("t1_rdy2", ren_ps2_rdy, 1);
    chk("t1_pr32", phys_ready[32], 0);

    // add x6,x5,x5 back to back
    dec(1, 5, 5, 6, 1, 33);
    tick();
    chk("t2_ps1", ren_ps1, 32);
    chk("t2_ps2", ren_ps2, 32);
    chk("t2_rdy1", ren_ps1_rdy, 0);
    chk("t2_rdy2", ren_ps2_rdy, 0);
    chk("t2_pd", ren_pd, 33);
    chk("t2_old", ren_old_pd, 6);

    // Hold for three cycles, CDB tag 32 in the second
    ren_ready = 0;
    dec(1, 1, 1, 7, 1, 34);
    #1 chk("t3_dready0", dec_ready, 0);
    tick();
    chk("t3_rdy1_a", ren_ps1_rdy, 0);
    cdb_valid = 1; cdb_pd = 32;
    tick();
    cdb_valid = 0;
    chk("t3_rdy1_b", ren_ps1_rdy, 1);
    chk("t3_rdy2_b", ren_ps2_rdy, 1);
    chk("t3_pd_hold", ren_pd, 33);
    chk("t3_ps1_hold", ren_ps1, 32);
    tick();
    chk("t3_dready1", dec_ready, 0);
    chk("t3_valid", ren_valid, 1);
    ren_ready = 1;
    tick();
    chk("t3_x7_pd", ren_pd, 34);
    chk("t3_x7_old", ren_old_pd, 7);

    // CDB in the same cycle as the lookup
    dec(1, 6, 0, 8, 1, 35);
    cdb_valid = 1; cdb_pd = 33;
    tick();
    cdb_valid = 0;
    chk("t2b_ps1", ren_ps1, 33);
    chk("t2b_rdy1", ren_ps1_rdy, 1);
    chk("t2b_ps2", ren_ps2, 0);
    chk("t2b_rdy2", ren_ps2_rdy, 1);

    // rd = x0 with write enable
    dec(1, 5, 6, 0, 1, 36);
    #1 chk("t4_x0_need", need_free_reg, 0);
    chk("t4_x0_dready", dec_ready, 1);
    tick();
    chk("t4_x0_pd", ren_pd, 0);
    chk("t4_x0_old", ren_old_pd, 0);

    // x7 with no free register available
    reg_available = 0;
    dec(1, 0, 0, 7, 1, 36);
    #1 chk("t4_stall_a", dec_ready, 0);
    tick();
    chk("t4_drain", ren_valid, 0);
    tick();
    chk("t4_stall_b", dec_ready, 0);
    reg_available = 1;
    #1 chk("t4_go", dec_ready, 1);
    tick();
    chk("t4_x7_pd", ren_pd, 36);
    chk("t4_x7_old", ren_old_pd, 34);
    dec(1, 0, 5, 9, 0, 0);
    tick();
    chk("t4_x0_map", ren_ps1, 0);
    chk("t4_x5_map", ren_ps2, 32);

    // Flush with x5->40 while a bundle is valid and decode is valid
    rrf[5] = 40;
    dec(1, 5, 7, 10, 1, 37);
    flush = 1;
    #1 chk("t5_dready", dec_ready, 0);
    chk("t5_need", need_free_reg, 0);
    tick();
    flush = 0;
    chk("t5_valid", ren_valid, 0);
    chk("t5_pr", phys_ready, {64{1'b1}});
    dec(1, 5, 7, 11, 0, 0);
    tick();
    chk("t5_ps1", ren_ps1, 40);
    chk("t5_ps2", ren_ps2, 7);
    chk("t5_old", ren_old_pd, 11);

    // Reset during a stalled bundle
    dec(1, 5, 1, 12, 1, 41);
    tick();
    chk("t6_pd", ren_pd, 41);
    ren_ready = 0;
    tick();
    chk("t6_held", ren_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    dec(0, 0, 0, 0, 0, 0);
    chk("t6_valid", ren_valid, 0);
    chk("t6_pr", phys_ready, {64{1'b1}});
    ren_ready = 1;
    dec(1, 5, 12, 13, 0, 0);
    tick();
    chk("t6_ps1", ren_ps1, 5);
    chk("t6_ps2", ren_ps2, 12);

    dec(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_map_stage.md
Name: rename_map_stage

Overview:
- Rename stage of the OOO core; sits between decode and dispatch.
- Holds the speculative RAT (arch->phys map) and the physical-register ready vector.
- Pulls one destination register per cycle from the free list and presents one renamed instruction per cycle to dispatch through a single output register.
- On flush, restores the map from the retirement RAT (RRF).

Parameters:
- NUM_REGS, 64, number of physical registers.
- PW, $clog2(NUM_REGS), physical tag width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  mispredict/exception flush
- rrf_arch_to_physical  in  PW x32  committed map from RRF
- dec_valid  in  1  decoded instruction valid
- dec_ready  out  1  stage accepts instruction this cycle
- dec_rs1, dec_rs2, dec_rd  in  5 each  architectural registers
- dec_rd_we  in  1  instruction writes rd
- need_free_reg  out  1  allocation request to free list
- arch_rd  out  5  rd forwarded to free list
- free_reg  in  PW  tag offered by free list
- reg_available  in  1  free_reg is valid
- cdb_valid  in  1  writeback broadcast valid
- cdb_pd  in  PW  tag written back
- ren_valid  out  1  renamed bundle valid
- ren_ready  in  1  dispatch accepts bundle
- ren_ps1, ren_ps2, ren_pd, ren_old_pd  out  PW each  source, dest and previous-dest tags
- ren_ps1_rdy, ren_ps2_rdy  out  1 each  source operands available
- phys_ready  out  NUM_REGS  ready bit per physical register

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state:
  - map[i]=i for i=0..31.
  - phys_ready all 1.
  - ren_valid=0; all ren_* tags 0.
- Derived signals:
  - alloc = dec_rd_we && dec_rd!=0.
  - fire = dec_valid && dec_ready.
- Handshakes:
  - dec_ready = !flush && (!ren_valid || ren_ready) && (!alloc || reg_available).
  - need_free_reg = fire && alloc (same cycle; the free list marks its tag busy at the edge).
  - arch_rd = dec_rd.
- Rename on fire (registered; 1-cycle latency from decode to ren_valid):
  - ps1=map[rs1], ps2=map[rs2]; old_pd=map[rd].
  - pd = alloc ? free_reg : 0.
  - map[rd]<=free_reg when alloc.
  - Reads use the pre-update map, so rs==rd reads the old tag.
- Source readiness:
  - rdy = phys_ready[ps] || (cdb_valid && cdb_pd==ps).
  - Tag 0 is always ready.
- Ready vector:
  - cdb_valid sets phys_ready[cdb_pd] (ignored for tag 0).
  - alloc on fire clears phys_ready[free_reg]; clear wins over a simultaneous CDB set to the same tag.
  - phys_ready[0] is constant 1.
- Output register:
  - Loads on fire.
  - If ren_valid && ren_ready && !fire, then ren_valid<=0.
  - Holds while ren_valid && !ren_ready. While held, it snoops the CDB: it sets ren_psX_rdy when cdb_valid && cdb_pd==ren_psX.
- Back-to-back: consecutive instructions need no bypass; the map updates at the edge before the next read.
- Flush (priority over fire):
  - map<=rrf_arch_to_physical; phys_ready<=all 1.
  - ren_valid<=0; dec_ready=0; need_free_reg=0 that cycle.
- Reset mid-operation: overrides flush and fire; produces the reset state next cycle.
- Stall cases:
  - reg_available=0 with alloc: stall; no map or ready change.
  - Instructions without alloc still proceed.
- x0 handling: map[0] is never written and stays 0.

Test Plan:
- Reset, then add x5,x1,x2 with free_reg=32 -> next cycle ren_valid=1, ps1=1, ps2=2, pd=32, old_pd=5, both rdy=1; map[5]=32; phys_ready[32]=0.
- Back-to-back add x6,x5,x5 (free_reg=33) following the above -> ps1=ps2=32, rdy=0, pd=33, old_pd=6; with cdb_pd=32 in the same cycle -> rdy=1.
- ren_ready=0 for 3 cycles with bundle ps1=32 unready, cdb_pd=32 in cycle 2 -> bundle held, dec_ready=0, ren_ps1_rdy rises after cycle 2, fields otherwise stable.
- rd=x0 with dec_rd_we=1, and reg_available=0 with rd=x7 -> x0 case: need_free_reg=0, pd=0, map unchanged; x7 case: dec_ready=0 until reg_available=1.
- Flush with rrf mapping x5->40 while ren_valid=1 -> next cycle ren_valid=0, map[5]=40, phys_ready all 1; flush concurrent with dec_valid -> no allocation.
- rst asserted during stalled bundle -> next cycle identity map, ren_valid=0, phys_ready all 1.
